dpbram_stream_reader: RTL and testbench

Read-side initiator for the team's dual-port BRAM (`wbDPBRAM`). It drives the BRAM's port B read interface (`i_enB`/`i_addrB` → `o_doutB`) to fetch a contiguous block of words. It re-emits those words as a valid/ready stream with a last-beat marker and absorbs the BRAM's one-cycle read latency and downstream backpressure. It sits between the BRAM and any stream consumer (UART TX, DMA sink), as the counterpart to logic that fills the BRAM through port A.

---
 rtl/dpbram_pkg.sv | 14 +
 rtl/dpbram_rd_fifo.sv | 52 +++++
 rtl/wbDPBRAM.sv | 31 +++
 rtl/dpbram_stream_reader.sv | 126 ++++++++++++
 tb/tb_dpbram_stream_reader.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dpbram_pkg.sv
// Shared definitions for the dual-port BRAM stream reader and other wbDPBRAM users.
// Holds the reader FSM state encoding and the default BRAM geometry.
package dpbram_pkg;

  localparam int DPB_DATA_WIDTH = 32;
  localparam int DPB_ADDR_WIDTH = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/dpbram_rd_fifo.sv
// Small synchronous FIFO buffering BRAM read returns (data plus last bit).
// Head outputs read as zero while empty so the stream outputs are clean after reset.
module dpbram_rd_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_valid,
  output logic [WIDTH-1:0]         o_head
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q;
  logic             do_push, do_pop;

  assign do_push = i_push && (count_q != (PW+1)'(DEPTH));
  assign do_pop  = i_pop && (count_q != '0);

  // NOTE: storage is deliberately not reset; the pointers and count define what is valid.
  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_push_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign o_count = count_q;
  assign o_valid = (count_q != '0);
  assign o_head  = o_valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/wbDPBRAM.sv
// Dual-port block RAM: port A read/write, port B read-only.
// Both ports have a one-cycle registered read latency.
module wbDPBRAM #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_enA,
  input  logic                  i_weA,
  input  logic [ADDR_WIDTH-1:0] i_addrA,
  input  logic [DATA_WIDTH-1:0] i_dinA,
  output logic [DATA_WIDTH-1:0] o_doutA,
  input  logic                  i_enB,
  input  logic [ADDR_WIDTH-1:0] i_addrB,
  output logic [DATA_WIDTH-1:0] o_doutB
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge i_clk) begin
    if (i_enA) begin
      if (i_weA) mem_q[i_addrA] <= i_dinA;
      o_doutA <= mem_q[i_addrA];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_enB) o_doutB <= mem_q[i_addrB];
  end

endmodule

// File: rtl/dpbram_stream_reader.sv
// Fetches a contiguous block from BRAM port B and re-emits it as a valid/ready stream.
// Reads are issued only when FIFO occupancy plus the in-flight read leave room.
module dpbram_stream_reader
  import dpbram_pkg::*;
#(
  parameter int DATA_WIDTH = DPB_DATA_WIDTH,
  parameter int ADDR_WIDTH = DPB_ADDR_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base,
  input  logic [ADDR_WIDTH:0]   i_len,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_enB,
  output logic [ADDR_WIDTH-1:0] o_addrB,
  input  logic [DATA_WIDTH-1:0] i_doutB,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last,
  input  logic                  i_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  rd_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] hold_q, hold_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic                  done_q, done_d;
  logic                  inflight_q, inflight_last_q;

  logic [CW-1:0]         occupancy;
  logic [CW:0]           outstanding;
  logic                  credit, issue, pop, head_valid;
  logic [DATA_WIDTH:0]   head;

  assign outstanding = {1'b0, occupancy} + {{CW{1'b0}}, inflight_q};
  assign credit      = outstanding < (CW+1)'(FIFO_DEPTH);
  assign issue       = (state_q == ST_ISSUE) && credit;
  assign pop         = head_valid && i_ready;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    hold_d  = hold_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          if (i_len == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d  = i_base;
            rem_d   = i_len;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (issue) begin
          addr_d = addr_q + ADDR_WIDTH'(1);
          hold_d = addr_q;
          rem_d  = rem_q - (ADDR_WIDTH+1)'(1);
          if (rem_q == (ADDR_WIDTH+1)'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && head[DATA_WIDTH]) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      hold_q          <= '0;
      rem_q           <= '0;
      done_q          <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      hold_q          <= hold_d;
      rem_q           <= rem_d;
      done_q          <= done_d;
      inflight_q      <= issue;
      inflight_last_q <= issue && (rem_q == (ADDR_WIDTH+1)'(1));
    end
  end

  // Read data returns one cycle after issue; push it tagged with its last flag.
  dpbram_rd_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_push      (inflight_q),
    .i_push_data ({inflight_last_q, i_doutB}),
    .i_pop       (pop),
    .o_count     (occupancy),
    .o_valid     (head_valid),
    .o_head      (head)
  );

  // The address shows the next read while issuing and otherwise holds the last one issued.
  assign o_enB   = issue;
  assign o_addrB = issue ? addr_q : hold_q;
  assign o_busy  = (state_q != ST_IDLE);
  assign o_done  = done_q;
  assign o_valid = head_valid;
  assign o_data  = head[DATA_WIDTH-1:0];
  assign o_last  = head[DATA_WIDTH];

endmodule

// File: tb/tb_dpbram_stream_reader.sv
// Self-checking bench: real wbDPBRAM preloaded via port A, reader on port B,
// scoreboard of expected beats filled at start and drained as the stream hands off.
module tb_dpbram_stream_reader;
  import dpbram_pkg::*;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int FD = 4;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic          i_reset, i_start, i_ready;
  logic [AW-1:0] i_base;
  logic [AW:0]   i_len;
  logic          o_busy, o_done, o_enB, o_valid, o_last;
  logic [AW-1:0] o_addrB;
  logic [DW-1:0] o_data, dout_b, dout_a;
  logic          en_a, we_a;
  logic [AW-1:0] addr_a;
  logic [DW-1:0] din_a;

  wbDPBRAM #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_bram (
    .i_clk(i_clk), .i_enA(en_a), .i_weA(we_a), .i_addrA(addr_a), .i_dinA(din_a),
    .o_doutA(dout_a), .i_enB(o_enB), .i_addrB(o_addrB), .o_doutB(dout_b)
  );

  dpbram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_base(i_base), .i_len(i_len),
    .o_busy(o_busy), .o_done(o_done), .o_enB(o_enB), .o_addrB(o_addrB), .i_doutB(dout_b),
    .o_valid(o_valid), .o_data(o_data), .o_last(o_last), .i_ready(i_ready)
  );

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  typedef struct {
    logic [AW-1:0] base;
    logic [AW:0]   len;
    logic [3:0]    ready_pat;
    int            exp_beats;
    int            exp_done;
  } vec_t;

  logic [DW-1:0] model [2**AW];
  beat_t         exp_q[$];
  logic [AW-1:0] addr_log[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int beats, done_cnt, en_cnt, valid_cnt, issues, pops, outst_viol;
  int first_en, first_valid, done_cyc;
  logic busy_at_done, prev_stall;
  logic [DW:0] prev_beat;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stream monitor, sampling mid-cycle on the falling edge.
  always @(negedge i_clk) begin
    if (i_reset) begin
      prev_stall = 1'b0;
    end else begin
      if (o_enB) begin
        en_cnt++;
        issues++;
        addr_log.push_back(o_addrB);
        if (first_en < 0) first_en = cyc;
      end
      if (issues - pops > FD) outst_viol++;
      if (o_valid) begin
        valid_cnt++;
        if (first_valid < 0) first_valid = cyc;
        if (prev_stall) check("stall_stable", {o_last, o_data}, prev_beat);
      end
      if (o_valid && i_ready) begin
        beats++;
        pops++;
        if (exp_q.size() == 0) begin
          check("extra_beat", 1, 0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_data", o_data, e.data);
          check("beat_last", o_last, e.last);
        end
      end
      if (o_done) begin
        done_cnt++;
        done_cyc     = cyc;
        busy_at_done = o_busy;
      end
      prev_stall = o_valid && !i_ready;
      prev_beat  = {o_last, o_data};
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_mon();
    beats = 0; done_cnt = 0; en_cnt = 0; valid_cnt = 0;
    issues = 0; pops = 0; outst_viol = 0;
    first_en = -1; first_valid = -1; done_cyc = -1; busy_at_done = 1'b1;
    exp_q.delete();
    addr_log.delete();
  endtask

  task automatic start_xfer(input logic [AW-1:0] base, input logic [AW:0] len, output int c0);
    for (int i = 0; i < int'(len); i++) begin
      beat_t         b;
      logic [AW-1:0] a;
      a      = base + AW'(i);
      b.data = model[a];
      b.last = (i == int'(len) - 1);
      exp_q.push_back(b);
    end
    i_base  = base;
    i_len   = len;
    i_start = 1'b1;
    c0      = cyc;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_done(input logic [3:0] pat, input int budget);
    int k;
    k = 0;
    while (done_cnt == 0 && k < budget) begin
      i_ready = pat[k % 4];
      tick();
      k++;
    end
    if (done_cnt == 0) check("done_timeout", 0, 1);
    i_ready = 1'b1;
  endtask

  task automatic check_addrs(input logic [AW-1:0] base, input logic [AW:0] len);
    int errs;
    errs = 0;
    for (int i = 0; i < addr_log.size(); i++)
      if (addr_log[i] !== base + AW'(i)) errs++;
    check("addr_count", addr_log.size(), len);
    check("addr_seq_errors", errs, 0);
  endtask

  initial begin
    vec_t          vecs[7];
    int            c0;
    logic [AW-1:0] wrap_exp[4];

    i_reset = 1'b1; i_start = 1'b0; i_ready = 1'b1; i_base = '0; i_len = '0;
    en_a = 1'b0; we_a = 1'b0; addr_a = '0; din_a = '0;
    clear_mon();

    // Preload every word with 0x100 + address while the reader is held in reset.
    for (int a = 0; a < 2**AW; a++) begin
      en_a = 1'b1; we_a = 1'b1; addr_a = AW'(a); din_a = DW'(32'h100 + a);
      model[a] = DW'(32'h100 + a);
      tick();
    end
    en_a = 1'b0; we_a = 1'b0;

    @(negedge i_clk);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_enB", o_enB, 0);
    check("rst_addrB", o_addrB, 0);
    check("rst_valid", o_valid, 0);
    check("rst_last", o_last, 0);
    check("rst_data", o_data, 0);
    i_reset = 1'b0;
    tick();

    // Latency and back-to-back timing: base 2, len 4, consumer always ready.
    clear_mon();
    start_xfer(AW'(2), (AW+1)'(4), c0);
    check("busy_after_start", o_busy, 1);
    wait_done(4'b1111, 200);
    check("lat_first_en", first_en, c0 + 1);
    check("lat_first_addr", addr_log[0], 2);
    check("lat_first_valid", first_valid, c0 + 3);
    check("lat_done_cycle", done_cyc, c0 + 7);
    check("busy_low_at_done", busy_at_done, 0);

    // Wrap: addresses must follow 1022, 1023, 0, 1.
    clear_mon();
    wrap_exp = '{AW'(1022), AW'(1023), AW'(0), AW'(1)};
    start_xfer(AW'(1022), (AW+1)'(4), c0);
    wait_done(4'b1111, 200);
    for (int i = 0; i < 4; i++) check("wrap_addr", addr_log[i], wrap_exp[i]);

    // Table-driven transfers with assorted ready patterns.
    vecs[0] = '{AW'(2),    (AW+1)'(4),    4'b1111, 4,    1};
    vecs[1] = '{AW'(1022), (AW+1)'(4),    4'b1111, 4,    1};
    vecs[2] = '{AW'(5),    (AW+1)'(16),   4'b1001, 16,   1};
    vecs[3] = '{AW'(1020), (AW+1)'(9),    4'b0101, 9,    1};
    vecs[4] = '{AW'(700),  (AW+1)'(1),    4'b0011, 1,    1};
    vecs[5] = '{AW'(512),  (AW+1)'(1024), 4'b1111, 1024, 1};
    vecs[6] = '{AW'(33),   (AW+1)'(0),    4'b1111, 0,    1};
    for (int v = 0; v < 7; v++) begin
      clear_mon();
      start_xfer(vecs[v].base, vecs[v].len, c0);
      wait_done(vecs[v].ready_pat, 5000);
      repeat (3) tick();
      check("tbl_beats", beats, vecs[v].exp_beats);
      check("tbl_done_count", done_cnt, vecs[v].exp_done);
      check("tbl_scoreboard_left", exp_q.size(), 0);
      check("tbl_outstanding_viol", outst_viol, 0);
      check("tbl_busy_idle", o_busy, 0);
      check_addrs(vecs[v].base, vecs[v].len);
    end

    // Zero length: done the next cycle, no reads, no beats, never busy.
    clear_mon();
    start_xfer(AW'(7), (AW+1)'(0), c0);
    check("zero_busy", o_busy, 0);
    repeat (4) tick();
    check("zero_done_cycle", done_cyc, c0 + 1);
    check("zero_done_count", done_cnt, 1);
    check("zero_enB", en_cnt, 0);
    check("zero_valid", valid_cnt, 0);

    // Start while busy is ignored.
    clear_mon();
    start_xfer(AW'(10), (AW+1)'(8), c0);
    tick();
    tick();
    i_base = AW'(100); i_len = (AW+1)'(3); i_start = 1'b1;
    tick();
    i_start = 1'b0;
    wait_done(4'b1111, 200);
    repeat (6) tick();
    check("busy_start_beats", beats, 8);
    check("busy_start_done", done_cnt, 1);
    check("busy_start_enB", en_cnt, 8);
    check_addrs(AW'(10), (AW+1)'(8));

    // Reset after 3 of 8 beats aborts cleanly.
    clear_mon();
    start_xfer(AW'(0), (AW+1)'(8), c0);
    begin
      int k;
      k = 0;
      while (beats < 3 && k < 100) begin
        tick();
        k++;
      end
      if (beats < 3) check("reset_wait_timeout", 0, 1);
    end
    i_ready = 1'b0;
    i_reset = 1'b1;
    tick();
    @(negedge i_clk);
    check("abort_busy", o_busy, 0);
    check("abort_done", o_done, 0);
    check("abort_enB", o_enB, 0);
    check("abort_addrB", o_addrB, 0);
    check("abort_valid", o_valid, 0);
    check("abort_last", o_last, 0);
    check("abort_data", o_data, 0);
    i_reset = 1'b0;
    i_ready = 1'b1;
    repeat (4) tick();
    check("abort_no_done", done_cnt, 0);

    clear_mon();
    start_xfer(AW'(0), (AW+1)'(2), c0);
    wait_done(4'b1111, 200);
    repeat (3) tick();
    check("post_reset_beats", beats, 2);
    check("post_reset_done", done_cnt, 1);
    check("post_reset_left", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
